sprite_blitter: RTL

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter_pkg.sv | 22 ++
 rtl/sprite_blitter_shifter.sv | 18 +
 rtl/sprite_blitter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_pkg.sv
// Shared blitter definitions: opcodes, framebuffer geometry, FSM state encoding.
package sprite_blitter_pkg;

  localparam int unsigned FB_WIDTH  = 128;
  localparam int unsigned FB_HEIGHT = 64;
  localparam int unsigned FB_BYTES  = 1024;

  localparam logic [2:0] BLIT_OP_NOP    = 3'd0;
  localparam logic [2:0] BLIT_OP_SPRITE = 3'd1;
  localparam logic [2:0] BLIT_OP_CLEAR  = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_SFETCH, S_SWAIT, S_RDL, S_LWAIT, S_WRL,
    S_RDR, S_RWAIT, S_WRR, S_NEXT, S_CLEAR, S_DONE
  } blit_state_t;

  // Height 0 selects the 16x16 sprite: 16 rows of 2 bytes.
  function automatic logic [5:0] sprite_nbytes(input logic [3:0] height);
    return (height == 4'd0) ? 6'd32 : {2'b00, height};
  endfunction

endpackage

// File: rtl/sprite_blitter_shifter.sv
// Splits one sprite byte across two framebuffer bytes for a given bit offset.
module sprite_shifter (
  input  logic [7:0] sprite_byte,
  input  logic [2:0] offset,
  output logic [7:0] left_mask,
  output logic [7:0] right_mask
);

  logic [15:0] spread;

  // Right half is byte << (8 - offset), which is zero when offset is zero.
  always_comb begin
    spread     = {sprite_byte, 8'h00} >> offset;
    left_mask  = spread[15:8];
    right_mask = spread[7:0];
  end

endmodule

// File: rtl/sprite_blitter.sv
// XOR sprite blitter and clear engine for a 128x64 (or 64x32) 1-bit framebuffer.
module sprite_blitter
  import sprite_blitter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hires,
  input  logic        blit_enable,
  input  logic [2:0]  blit_op,
  input  logic [11:0] blit_src,
  input  logic [3:0]  blit_srcHeight,
  input  logic [6:0]  blit_destX,
  input  logic [5:0]  blit_destY,
  output logic        spr_en,
  output logic [11:0] spr_addr,
  input  logic [7:0]  spr_data,
  output logic        fb_en,
  output logic        fb_wr,
  output logic [9:0]  fb_addr,
  output logic [7:0]  fb_din,
  input  logic [7:0]  fb_dout,
  output logic        blit_busy,
  output logic        blit_done,
  output logic        blit_collision
);

  blit_state_t state, state_next;

  logic        hires_q;
  logic [11:0] src_q;
  logic [3:0]  height_q;
  logic [6:0]  dest_x_q;
  logic [5:0]  dest_y_q;
  logic [5:0]  byte_idx;
  logic [9:0]  clr_cnt;
  logic [7:0]  spr_byte;
  logic [7:0]  fb_old;
  logic        collision;

  logic        wide;
  logic        last_byte;
  logic [6:0]  px;
  logic [5:0]  row;
  logic [3:0]  col_l, col_r;
  logic [9:0]  addr_l, addr_r;
  logic [7:0]  mask_l, mask_r;

  // In 16x16 mode odd bytes sit 8 pixels right and two bytes share a row.
  always_comb begin
    wide      = (height_q == 4'd0);
    last_byte = (byte_idx == sprite_nbytes(height_q) - 6'd1);
    px        = dest_x_q + ((wide && byte_idx[0]) ? 7'd8 : 7'd0);
    row       = dest_y_q + (wide ? {1'b0, byte_idx[5:1]} : byte_idx);
    col_l     = px[6:3];
    col_r     = px[6:3] + 4'd1;
    if (!hires_q) begin
      row[5]   = 1'b0;
      col_l[3] = 1'b0;
      col_r[3] = 1'b0;
    end
    addr_l = {row, col_l};
    addr_r = {row, col_r};
  end

  sprite_shifter u_shifter (
    .sprite_byte (spr_byte),
    .offset      (px[2:0]),
    .left_mask   (mask_l),
    .right_mask  (mask_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (blit_enable) begin
          case (blit_op)
            BLIT_OP_SPRITE: state_next = S_SFETCH;
            BLIT_OP_CLEAR:  state_next = S_CLEAR;
            default:        state_next = S_DONE;
          endcase
        end
      end
      S_SFETCH: state_next = S_SWAIT;
      S_SWAIT:  state_next = S_RDL;
      S_RDL:    state_next = S_LWAIT;
      S_LWAIT:  state_next = S_WRL;
      S_WRL:    state_next = S_RDR;
      S_RDR:    state_next = S_RWAIT;
      S_RWAIT:  state_next = S_WRR;
      S_WRR:    state_next = last_byte ? S_NEXT : S_SFETCH;
      S_NEXT:   state_next = S_DONE;
      S_CLEAR:  state_next = (clr_cnt == 10'h3FF) ? S_DONE : S_CLEAR;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    spr_en    = (state == S_SFETCH);
    spr_addr  = '0;
    fb_en     = 1'b0;
    fb_wr     = 1'b0;
    fb_addr   = '0;
    fb_din    = '0;
    if (state == S_SFETCH) spr_addr = src_q + {6'b0, byte_idx};
    case (state)
      S_RDL:   begin fb_en = 1'b1; fb_addr = addr_l; end
      S_LWAIT: fb_addr = addr_l;
      S_WRL:   begin fb_en = 1'b1; fb_wr = 1'b1; fb_addr = addr_l; fb_din = fb_old ^ mask_l; end
      S_RDR:   begin fb_en = 1'b1; fb_addr = addr_r; end
      S_RWAIT: fb_addr = addr_r;
      S_WRR:   begin fb_en = 1'b1; fb_wr = 1'b1; fb_addr = addr_r; fb_din = fb_old ^ mask_r; end
      S_CLEAR: begin fb_en = 1'b1; fb_wr = 1'b1; fb_addr = clr_cnt; end
      default: ;
    endcase
    blit_busy      = (state != S_IDLE);
    blit_done      = (state == S_DONE);
    blit_collision = collision;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hires_q   <= 1'b0;
      src_q     <= '0;
      height_q  <= '0;
      dest_x_q  <= '0;
      dest_y_q  <= '0;
      byte_idx  <= '0;
      clr_cnt   <= '0;
      spr_byte  <= '0;
      fb_old    <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (blit_enable) begin
            hires_q  <= hires;
            src_q    <= blit_src;
            height_q <= blit_srcHeight;
            dest_x_q <= blit_destX;
            dest_y_q <= blit_destY;
            byte_idx <= '0;
            clr_cnt  <= '0;
            // NOP and undefined opcodes keep the previous collision result.
            if (blit_op == BLIT_OP_SPRITE || blit_op == BLIT_OP_CLEAR) collision <= 1'b0;
          end
        end
        S_SWAIT: spr_byte <= spr_data;
        S_LWAIT: fb_old   <= fb_dout;
        S_RWAIT: fb_old   <= fb_dout;
        S_WRL:   collision <= collision | (|(fb_old & mask_l));
        S_WRR: begin
          collision <= collision | (|(fb_old & mask_r));
          byte_idx  <= byte_idx + 6'd1;
        end
        S_CLEAR: clr_cnt <= clr_cnt + 10'd1;
        default: ;
      endcase
    end
  end

endmodule
